// File: rtl/sap_ctrl_pkg.sv
// Shared constants for the SAP-1 controller-sequencer: opcodes, control-word
// bit positions, fixed control words and the one-hot ring states.
package sap_ctrl_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Bit positions within con = {Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}
    localparam int CON_CP  = 11;
    localparam int CON_EP  = 10;
    localparam int CON_NLM = 9;
    localparam int CON_NCE = 8;
    localparam int CON_NLI = 7;
    localparam int CON_NEI = 6;
    localparam int CON_NLA = 5;
    localparam int CON_EA  = 4;
    localparam int CON_SU  = 3;
    localparam int CON_EU  = 2;
    localparam int CON_NLB = 1;
    localparam int CON_NLO = 0;

    localparam logic [11:0] CON_NOP      = 12'h3E3;
    localparam logic [11:0] CON_FETCH1   = 12'h5E3;
    localparam logic [11:0] CON_FETCH2   = 12'hBE3;
    localparam logic [11:0] CON_FETCH3   = 12'h263;
    localparam logic [11:0] CON_ADDR_OUT = 12'h1A3;
    localparam logic [11:0] CON_LDA_T5   = 12'h2C3;
    localparam logic [11:0] CON_LDB_T5   = 12'h2E1;
    localparam logic [11:0] CON_ADD_T6   = 12'h3C7;
    localparam logic [11:0] CON_SUB_T6   = 12'h3CF;
    localparam logic [11:0] CON_OUT_T4   = 12'h3F2;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    function automatic logic is_onehot6(input logic [5:0] v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < 6; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return (cnt == 3'd1);
    endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// Falling-edge one-hot T1..T6 ring counter with async clear, hold and
// recovery of any non-one-hot state back to T1.
module sap_ring_counter
    import sap_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       hold,
    output logic [5:0] t_state
);

    logic [5:0] ring_r;

    // Ring register: recovery beats hold so a corrupted state never sticks
    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            ring_r <= T1;
        end else if (!is_onehot6(ring_r)) begin
            ring_r <= T1;
        end else if (hold) begin
            ring_r <= ring_r;
        end else begin
            ring_r <= {ring_r[4:0], ring_r[5]};
        end
    end

    assign t_state = ring_r;

endmodule

// File: rtl/sap_controller_sequencer.sv
// SAP-1 controller-sequencer: ring counter plus opcode decode into the 12-bit
// control word. Define SAP_SINGLE_STEP_EN to add the single-step input.
module sap_controller_sequencer
    import sap_ctrl_pkg::*;
#(
    parameter int OP_WIDTH = 4
) (
    input  logic                clk,
    input  logic                clr,
`ifdef SAP_SINGLE_STEP_EN
    input  logic                step,
`endif
    input  logic [OP_WIDTH-1:0] opcode,
    output logic [11:0]         con,
    output logic [5:0]          t_state,
    output logic                halted
);

    logic       halted_r;
    logic       advance_en_s;
    logic       hlt_at_t4_s;
    logic       hold_s;
    logic [11:0] con_s;

`ifdef SAP_SINGLE_STEP_EN
    assign advance_en_s = step;
`else
    assign advance_en_s = 1'b1;
`endif

    assign hlt_at_t4_s = (t_state == T4) && (opcode == OP_WIDTH'(OP_HLT));
    // Holding on HLT in T4 keeps the ring parked there as halted rises
    assign hold_s      = halted_r || hlt_at_t4_s || !advance_en_s;

    sap_ring_counter u_ring (
        .clk     (clk),
        .clr     (clr),
        .hold    (hold_s),
        .t_state (t_state)
    );

    // Halt flag: set on the advancing falling edge that ends an HLT T4
    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            halted_r <= 1'b0;
        end else if (hlt_at_t4_s && advance_en_s) begin
            halted_r <= 1'b1;
        end else begin
            halted_r <= halted_r;
        end
    end

    // Control-word decode from ring state and opcode
    always_comb begin
        con_s = CON_NOP;
        if (clr || halted_r) begin
            con_s = CON_NOP;
        end else begin
            case (t_state)
                T1: con_s = CON_FETCH1;
                T2: con_s = CON_FETCH2;
                T3: con_s = CON_FETCH3;
                T4: begin
                    if (opcode == OP_WIDTH'(OP_LDA) || opcode == OP_WIDTH'(OP_ADD) ||
                        opcode == OP_WIDTH'(OP_SUB)) begin
                        con_s = CON_ADDR_OUT;
                    end else if (opcode == OP_WIDTH'(OP_OUT)) begin
                        con_s = CON_OUT_T4;
                    end else begin
                        con_s = CON_NOP;
                    end
                end
                T5: begin
                    if (opcode == OP_WIDTH'(OP_LDA)) begin
                        con_s = CON_LDA_T5;
                    end else if (opcode == OP_WIDTH'(OP_ADD) || opcode == OP_WIDTH'(OP_SUB)) begin
                        con_s = CON_LDB_T5;
                    end else begin
                        con_s = CON_NOP;
                    end
                end
                T6: begin
                    if (opcode == OP_WIDTH'(OP_ADD)) begin
                        con_s = CON_ADD_T6;
                    end else if (opcode == OP_WIDTH'(OP_SUB)) begin
                        con_s = CON_SUB_T6;
                    end else begin
                        con_s = CON_NOP;
                    end
                end
                default: con_s = CON_NOP;
            endcase
        end
    end

    assign con    = con_s;
    assign halted = halted_r;

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Directed, table-driven bench for sap_controller_sequencer.
module tb_sap_controller_sequencer;

    logic        clk;
    logic        clr;
    logic [3:0]  opcode;
    logic [11:0] con;
    logic [5:0]  t_state;
    logic        halted;
`ifdef SAP_SINGLE_STEP_EN
    logic        step;
`endif

    int total;
    int bad;

    typedef struct {
        logic [3:0]  op;
        logic [11:0] c4;
        logic [11:0] c5;
        logic [11:0] c6;
    } vec_t;

    vec_t vecs [6];

    sap_controller_sequencer #(.OP_WIDTH(4)) dut (
        .clk     (clk),
        .clr     (clr),
`ifdef SAP_SINGLE_STEP_EN
        .step    (step),
`endif
        .opcode  (opcode),
        .con     (con),
        .t_state (t_state),
        .halted  (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Pulse clr between edges, check reset state, leave DUT in T1.
    task automatic do_reset();
        @(negedge clk);
        #2 clr = 1'b1;
        #1;
        chk("rst_t_state", {6'd0, t_state}, 12'h001);
        chk("rst_con", con, 12'h3E3);
        chk("rst_halted", {11'd0, halted}, 12'h000);
        #1 clr = 1'b0;
        #0.5;
        chk("rel_con", con, 12'h5E3);
    endtask

    task automatic step_chk(input string nm, input logic [5:0] ts, input logic [11:0] c);
        @(negedge clk);
        #1;
        chk({nm, "_ts"}, {6'd0, t_state}, {6'd0, ts});
        chk({nm, "_con"}, con, c);
    endtask

    initial begin
        total = 0;
        bad = 0;
        clr = 1'b0;
        opcode = 4'b0000;
`ifdef SAP_SINGLE_STEP_EN
        step = 1'b1;
`endif
        vecs[0] = '{op: 4'b0000, c4: 12'h1A3, c5: 12'h2C3, c6: 12'h3E3};
        vecs[1] = '{op: 4'b0001, c4: 12'h1A3, c5: 12'h2E1, c6: 12'h3C7};
        vecs[2] = '{op: 4'b0010, c4: 12'h1A3, c5: 12'h2E1, c6: 12'h3CF};
        vecs[3] = '{op: 4'b1110, c4: 12'h3F2, c5: 12'h3E3, c6: 12'h3E3};
        vecs[4] = '{op: 4'b0101, c4: 12'h3E3, c5: 12'h3E3, c6: 12'h3E3};
        vecs[5] = '{op: 4'b1010, c4: 12'h3E3, c5: 12'h3E3, c6: 12'h3E3};

        #2 clr = 1'b1;
        #1;
        chk("init_t_state", {6'd0, t_state}, 12'h001);
        chk("init_con", con, 12'h3E3);
        #1 clr = 1'b0;

        for (int i = 0; i < 6; i++) begin
            opcode = vecs[i].op;
            do_reset();
            step_chk("t2", 6'b000010, 12'hBE3);
            step_chk("t3", 6'b000100, 12'h263);
            step_chk("t4", 6'b001000, vecs[i].c4);
            step_chk("t5", 6'b010000, vecs[i].c5);
            step_chk("t6", 6'b100000, vecs[i].c6);
            step_chk("wrap", 6'b000001, 12'h5E3);
            chk("no_halt", {11'd0, halted}, 12'h000);
        end

        // Opcode changes during fetch must not matter; T4 uses the value present then
        opcode = 4'b1111;
        do_reset();
        step_chk("f_t2", 6'b000010, 12'hBE3);
        opcode = 4'b1110;
        #1;
        chk("f_t2_opchg", con, 12'hBE3);
        step_chk("f_t3", 6'b000100, 12'h263);
        opcode = 4'b0001;
        step_chk("f_t4", 6'b001000, 12'h1A3);

        // HLT: halt after T4 and stay frozen
        opcode = 4'b1111;
        do_reset();
        step_chk("h_t2", 6'b000010, 12'hBE3);
        step_chk("h_t3", 6'b000100, 12'h263);
        step_chk("h_t4", 6'b001000, 12'h3E3);
        chk("h_t4_halted", {11'd0, halted}, 12'h000);
        for (int k = 0; k < 20; k++) begin
            step_chk("h_hold", 6'b001000, 12'h3E3);
            chk("h_halted", {11'd0, halted}, 12'h001);
        end
        opcode = 4'b0000;
        step_chk("h_hold_op", 6'b001000, 12'h3E3);
        do_reset();
        step_chk("h_exit_t2", 6'b000010, 12'hBE3);

        // clr mid-instruction, asserted in the high phase of T5
        opcode = 4'b0001;
        do_reset();
        for (int k = 0; k < 4; k++) @(negedge clk);
        #1;
        chk("m_t5_con", con, 12'h2E1);
        @(posedge clk);
        #1 clr = 1'b1;
        #1;
        chk("m_clr_ts", {6'd0, t_state}, 12'h001);
        chk("m_clr_con", con, 12'h3E3);
        #1 clr = 1'b0;
        #0.5;
        chk("m_rel_con", con, 12'h5E3);
        step_chk("m_t2", 6'b000010, 12'hBE3);

`ifdef SAP_SINGLE_STEP_EN
        opcode = 4'b0000;
        do_reset();
        step = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step_chk("s_hold", 6'b000001, 12'h5E3);
        end
        step = 1'b1;
        step_chk("s_one", 6'b000010, 12'hBE3);
        step = 1'b0;
        step_chk("s_after", 6'b000010, 12'hBE3);
        step_chk("s_after2", 6'b000010, 12'hBE3);
        step = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sap_controller_sequencer.md
Name: sap_controller_sequencer

Overview:
- Controller-sequencer for the SAP-1 datapath: PC, MAR, RAM, instruction register, accumulator A, adder/subtractor, register B and output register.
- A 6-state ring counter (T1..T6) combines with the IR opcode nibble to decode the 12-bit control word that drives every datapath load and enable.
- Handles LDA, ADD, SUB, OUT and HLT. Register B is written only via nLb during ADD/SUB.

Parameters:
- OP_WIDTH, 4, width of the opcode field taken from IR[7:4].

Ports:
- clk  input  1  system clock; datapath registers load on the rising edge, this block updates on the falling edge.
- clr  input  1  asynchronous, active-high reset.
- opcode  input  OP_WIDTH  instruction opcode from IR upper nibble.
- con  output  12  control word {Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}; n-prefixed bits are active-low.
- t_state  output  6  one-hot ring state; bit0=T1 .. bit5=T6.
- halted  output  1  high once HLT has executed.

Behaviour:
- Reset (clr high, asynchronous): t_state=6'b000001 (T1), halted=0, con forced to NOP 12'h3E3 while clr is high.
- Ring counter:
  - Advances on each falling clk edge: T1->T2->...->T6->T1.
  - This gives control signals half a cycle to settle before the datapath's rising edge.
- con is combinational from t_state, opcode and halted. Bits not listed for a state are inactive (NOP value).
- Fetch, all opcodes:
  - T1 = 12'h5E3 (Ep, nLm).
  - T2 = 12'hBE3 (Cp).
  - T3 = 12'h263 (nCE, nLi).
- LDA (0000):
  - T4 = 12'h1A3 (nLm, nEi).
  - T5 = 12'h2C3 (nCE, nLa).
  - T6 = NOP.
- ADD (0001):
  - T4 = 12'h1A3.
  - T5 = 12'h2E1 (nCE, nLb).
  - T6 = 12'h3C7 (Eu, nLa).
- SUB (0010): same as ADD except T6 = 12'h3CF (Su, Eu, nLa).
- OUT (1110): T4 = 12'h3F2 (Ea, nLo); T5, T6 = NOP.
- HLT (1111):
  - In T4, con = NOP.
  - On the falling edge ending T4, halted<=1 and the ring holds at T4.
  - While halted: con=NOP, t_state frozen. Only clr exits.
- Undefined opcodes: T4..T6 = NOP; the ring continues normally.
- opcode is sampled combinationally only in T4..T6. Changes during T1..T3 have no effect.
- clr asserted mid-instruction: immediate return to T1/NOP. On release, the first falling edge moves to T2.
- Any non-one-hot t_state (unreachable) recovers to T1 on the next falling edge.

Optional Feature:
- Macro: SAP_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit, synchronous to clk).
  - The ring advances only on falling edges where step=1; otherwise it holds and con stays at the current state's word.
  - HLT and clr behaviour unchanged.
- Undefined: no step port; the ring advances on every falling edge.

Decomposition:
- Package sap_ctrl_pkg:
  - opcode constants OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT;
  - control-bit index constants CON_CP..CON_NLO;
  - CON_NOP=12'h3E3;
  - one-hot T1..T6 constants.
- Sub-module sap_ring_counter: falling-edge one-hot counter with async clr, hold input (driven by halted, and by step when SAP_SINGLE_STEP_EN is defined) and illegal-state recovery.
- Decode stays in the top module.

Test Plan:
- Pulse clr mid-cycle -> t_state=000001, con=12'h3E3, halted=0 immediately. After release, con=12'h5E3 until the next falling edge.
- opcode=0000 (LDA), run 6 falling edges -> con sequence 5E3, BE3, 263, 1A3, 2C3, 3E3, then back to 5E3.
- opcode=0001 then 0010 -> T5=12'h2E1 (nLb low exactly one state); T6=12'h3C7 for ADD, 12'h3CF for SUB.
- opcode=1110 -> T4=12'h3F2; T5/T6=12'h3E3.
- opcode=1111 -> after T4, halted=1, t_state=001000, con=3E3 held for 20 cycles. clr returns to T1 with halted=0.
- With SAP_SINGLE_STEP_EN defined, step=0 for 5 cycles -> t_state unchanged. A single-cycle step pulse -> exactly one advance. Undefined opcode 0101 -> T4..T6 NOP.
